// File: rtl/spi_axil_cmd_bridge_if.sv
// AXI4-Lite single-transfer bus between the SPI command bridge (master)
// and the downstream register bank (slave).
interface spi_axil_cmd_bridge_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/spi_axil_cmd_bridge.sv
// Decodes opcode/address/data frames from the SPI slave PHY byte stream and
// issues AXI4-Lite single transfers; read data is streamed back to the PHY.
module spi_axil_cmd_bridge #(
    parameter logic [7:0] OP_WRITE = 8'h02,
    parameter logic [7:0] OP_READ  = 8'h0B,
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cs_active_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    spi_axil_cmd_bridge_if.master m_axi,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_READ,
        ST_DISCARD,
        ST_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic        cs_q;
    logic        is_read;
    logic [1:0]  byte_cnt;
    logic [31:0] addr;
    logic [31:0] wr_word;

    logic        aw_v, w_v, b_rdy, ar_v, r_rdy;
    logic [31:0] aw_addr_q, w_data_q, ar_addr_q;

    logic [31:0] cur_word, nxt_word;
    logic        cur_valid, nxt_valid;
    logic [1:0]  tx_idx;
    logic        err_q;

    logic        cs_rise, rx_fire;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        wr_busy, rd_busy, axi_busy;
    logic [31:0] addr_shift, wr_shift;
    logic        wr_last, wr_issue, overrun;
    logic        rd_first, read_live, tx_load, word_done, prefetch, underrun;
    logic        resp_err;

    // A byte arriving on the same cycle cs drops belongs to no frame.
    assign cs_rise = cs_active_i && !cs_q;
    assign rx_fire = rx_valid_i && cs_active_i;

    assign aw_hs = aw_v && m_axi.awready;
    assign w_hs  = w_v && m_axi.wready;
    assign b_hs  = b_rdy && m_axi.bvalid;
    assign ar_hs = ar_v && m_axi.arready;
    assign r_hs  = r_rdy && m_axi.rvalid;

    assign wr_busy  = aw_v || w_v || b_rdy;
    assign rd_busy  = ar_v || r_rdy;
    assign axi_busy = wr_busy || rd_busy;

    assign addr_shift = {addr[23:0], rx_data_i};
    assign wr_shift   = {wr_word[23:0], rx_data_i};

    assign wr_last  = (state == ST_WDATA) && rx_fire && (byte_cnt == 2'd3);
    assign wr_issue = wr_last && !wr_busy;
    assign overrun  = wr_last && wr_busy;
    assign rd_first = (state == ST_ADDR) && rx_fire && (byte_cnt == 2'd3) && is_read;

    assign read_live = (state == ST_READ) && cs_active_i;
    assign tx_load   = tx_ready_i && cur_valid;
    assign word_done = tx_load && (tx_idx == 2'd3);
    assign prefetch  = read_live && tx_load && (tx_idx == 2'd0) && !rd_busy;
    assign underrun  = read_live && tx_ready_i && !cur_valid;
    assign resp_err  = (b_hs && (m_axi.bresp != 2'b00)) || (r_hs && (m_axi.rresp != 2'b00));

    assign m_axi.awaddr  = aw_addr_q;
    assign m_axi.awprot  = AXI_PROT;
    assign m_axi.awvalid = aw_v;
    assign m_axi.wdata   = w_data_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = w_v;
    assign m_axi.bready  = b_rdy;
    assign m_axi.araddr  = ar_addr_q;
    assign m_axi.arprot  = AXI_PROT;
    assign m_axi.arvalid = ar_v;
    assign m_axi.rready  = r_rdy;

    assign tx_valid_o = cur_valid;
    assign tx_data_o  = cur_valid ? cur_word[31:24] : 8'hFF;
    assign busy_o     = (state != ST_IDLE) || axi_busy;
    assign err_o      = err_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cs_rise) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (rx_fire) begin
                    if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) state_nxt = ST_ADDR;
                    else                                                 state_nxt = ST_DISCARD;
                end
            end
            ST_ADDR: begin
                if (rx_fire && byte_cnt == 2'd3) state_nxt = is_read ? ST_READ : ST_WDATA;
            end
            ST_DRAIN: begin
                if (!axi_busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = state;
        endcase
        // Frame end overrides everything: outstanding transfers finish in DRAIN.
        if (state != ST_IDLE && state != ST_DRAIN && !cs_active_i) begin
            state_nxt = axi_busy ? ST_DRAIN : ST_IDLE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cs_q      <= 1'b0;
            is_read   <= 1'b0;
            byte_cnt  <= '0;
            addr      <= '0;
            wr_word   <= '0;
            aw_v      <= 1'b0;
            w_v       <= 1'b0;
            b_rdy     <= 1'b0;
            ar_v      <= 1'b0;
            r_rdy     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            ar_addr_q <= '0;
        end else begin
            cs_q <= cs_active_i;

            if (state == ST_CMD) begin
                byte_cnt <= '0;
                if (rx_fire) is_read <= (rx_data_i == OP_READ);
            end
            if (state == ST_ADDR && rx_fire) begin
                addr     <= addr_shift;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == ST_WDATA && rx_fire) begin
                wr_word  <= wr_shift;
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (aw_hs) aw_v <= 1'b0;
            if (w_hs)  w_v  <= 1'b0;
            if (b_hs) begin
                b_rdy <= 1'b0;
                addr  <= addr + 32'd4;
            end
            if (wr_issue) begin
                aw_v      <= 1'b1;
                w_v       <= 1'b1;
                b_rdy     <= 1'b1;
                aw_addr_q <= addr;
                w_data_q  <= wr_shift;
            end

            // Read pointer advances on AR acceptance so a prefetch always targets the next word.
            if (ar_hs) begin
                ar_v <= 1'b0;
                addr <= addr + 32'd4;
            end
            if (r_hs) r_rdy <= 1'b0;
            if (rd_first) begin
                ar_v      <= 1'b1;
                r_rdy     <= 1'b1;
                ar_addr_q <= addr_shift;
            end
            if (prefetch) begin
                ar_v      <= 1'b1;
                r_rdy     <= 1'b1;
                ar_addr_q <= addr;
            end
        end
    end

    // Two-word read buffer: cur_word feeds the PHY, nxt_word holds the prefetched word.
    always_ff @(posedge ACLK) begin
        if (ARESET || !read_live) begin
            cur_word  <= '0;
            nxt_word  <= '0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            tx_idx    <= '0;
        end else begin
            if (tx_load) tx_idx <= tx_idx + 2'd1;
            if (word_done) begin
                if (nxt_valid) begin
                    cur_word  <= nxt_word;
                    nxt_word  <= m_axi.rdata;
                    nxt_valid <= r_hs;
                end else begin
                    cur_word  <= m_axi.rdata;
                    cur_valid <= r_hs;
                end
            end else begin
                if (tx_load) cur_word <= {cur_word[23:0], 8'hFF};
                if (r_hs) begin
                    if (cur_valid) begin
                        nxt_word  <= m_axi.rdata;
                        nxt_valid <= 1'b1;
                    end else begin
                        cur_word  <= m_axi.rdata;
                        cur_valid <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_q <= 1'b0;
        end else if (state == ST_IDLE && cs_rise) begin
            err_q <= 1'b0;
        end else if (resp_err || overrun || underrun) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_axil_cmd_bridge.sv
// Directed bench for spi_axil_cmd_bridge with a small AXI4-Lite slave model.
module tb_spi_axil_cmd_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err;

    logic       aw_block;
    logic [1:0] bresp_cfg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    logic [3:0]  strb_log[$];
    logic [31:0] ar_log[$];
    logic [31:0] mem [logic [31:0]];

    logic        aw_got, w_got;
    logic [31:0] aw_q, w_q;

    always #5 clk = ~clk;

    spi_axil_cmd_bridge_if bus ();

    spi_axil_cmd_bridge #(
        .OP_WRITE (8'h02),
        .OP_READ  (8'h0B),
        .AXI_PROT (3'b000)
    ) dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .cs_active_i (cs),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .m_axi       (bus),
        .busy_o      (busy),
        .err_o       (err)
    );

    assign bus.awready = !aw_block;
    assign bus.wready  = 1'b1;
    assign bus.arready = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.rresp  <= 2'b00;
        end else begin
            if (bus.awvalid && bus.awready) begin
                aw_got <= 1'b1;
                aw_q   <= bus.awaddr;
                aw_log.push_back(bus.awaddr);
            end
            if (bus.wvalid && bus.wready) begin
                w_got <= 1'b1;
                w_q   <= bus.wdata;
                w_log.push_back(bus.wdata);
                strb_log.push_back(bus.wstrb);
            end
            if (aw_got && w_got && !bus.bvalid) begin
                mem[aw_q] = w_q;
                bus.bvalid <= 1'b1;
                bus.bresp  <= bresp_cfg;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                ar_log.push_back(bus.araddr);
                bus.rvalid <= 1'b1;
                bus.rresp  <= 2'b00;
                bus.rdata  <= mem.exists(bus.araddr) ? mem[bus.araddr] : 32'hDEAD_BEEF;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int unsigned i = 0; i < 4; i++) begin
            send_byte(t[31:24]);
            t = t << 8;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_end();
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic clear_logs();
        aw_log.delete();
        w_log.delete();
        strb_log.delete();
        ar_log.delete();
    endtask

    logic [7:0] exp_rd [8];

    initial begin
        rst       = 1'b1;
        cs        = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        aw_block  = 1'b0;
        bresp_cfg = 2'b00;
        exp_rd    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        repeat (3) @(negedge clk);
        check("rst_awvalid", bus.awvalid, 1'b0);
        check("rst_wvalid", bus.wvalid, 1'b0);
        check("rst_bready", bus.bready, 1'b0);
        check("rst_arvalid", bus.arvalid, 1'b0);
        check("rst_rready", bus.rready, 1'b0);
        check("rst_tx_data", tx_data, 8'hFF);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word write from address 0
        clear_logs();
        cs_begin();
        send_byte(8'h02);
        send_word(32'h0000_0000);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        cs_end();
        wait_idle("t1_idle");
        check("t1_aw_count", aw_log.size(), 2);
        if (aw_log.size() == 2 && w_log.size() == 2) begin
            check("t1_awaddr0", aw_log[0], 32'h0);
            check("t1_wdata0", w_log[0], 32'h1);
            check("t1_awaddr1", aw_log[1], 32'h4);
            check("t1_wdata1", w_log[1], 32'h2);
            check("t1_wstrb", strb_log[0], 4'hF);
        end
        check("t1_err", err, 1'b0);

        // Preload 0x4/0x8, then burst read with prefetch
        clear_logs();
        cs_begin();
        send_byte(8'h02);
        send_word(32'h0000_0004);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        cs_end();
        wait_idle("t2_wr_idle");
        check("t2_wr_count", aw_log.size(), 2);
        clear_logs();
        cs_begin();
        send_byte(8'h0B);
        send_word(32'h0000_0004);
        send_byte(8'hFF);
        for (int unsigned i = 0; i < 8; i++) begin
            int n;
            n = 0;
            while (!tx_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t2_tx_valid", tx_valid, 1'b1);
            check($sformatf("t2_tx_byte%0d", i), tx_data, exp_rd[i]);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            repeat (4) @(negedge clk);
        end
        cs_end();
        check("t2_tx_valid_off", tx_valid, 1'b0);
        wait_idle("t2_rd_idle");
        check("t2_ar_count", ar_log.size(), 3);
        if (ar_log.size() == 3) begin
            check("t2_araddr0", ar_log[0], 32'h4);
            check("t2_araddr1", ar_log[1], 32'h8);
            check("t2_araddr2", ar_log[2], 32'hC);
        end
        check("t2_err", err, 1'b0);

        // Unknown opcode: frame discarded
        clear_logs();
        cs_begin();
        send_byte(8'h5A);
        send_word(32'h0102_0304);
        check("t3_busy_mid", busy, 1'b1);
        send_word(32'h0506_0708);
        cs_end();
        check("t3_busy_after", busy, 1'b0);
        check("t3_aw_count", aw_log.size(), 0);
        check("t3_ar_count", ar_log.size(), 0);

        // AW stalled across a frame end
        clear_logs();
        aw_block = 1'b1;
        cs_begin();
        send_byte(8'h02);
        send_word(32'h0000_0100);
        send_word(32'h0000_00AA);
        send_byte(8'h00);
        send_byte(8'h00);
        cs_end();
        for (int unsigned i = 0; i < 20; i++) begin
            check("t4_awvalid_hold", bus.awvalid, 1'b1);
            @(negedge clk);
        end
        check("t4_busy_hold", busy, 1'b1);
        aw_block = 1'b0;
        wait_idle("t4_idle");
        check("t4_aw_count", aw_log.size(), 1);
        if (aw_log.size() == 1 && w_log.size() == 1) begin
            check("t4_awaddr", aw_log[0], 32'h100);
            check("t4_wdata", w_log[0], 32'hAA);
        end

        // SLVERR on B: sticky until next frame start
        clear_logs();
        bresp_cfg = 2'b10;
        cs_begin();
        send_byte(8'h02);
        send_word(32'h0000_0200);
        send_word(32'h1234_5678);
        cs_end();
        wait_idle("t5_idle");
        check("t5_err_set", err, 1'b1);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", err, 1'b1);
        bresp_cfg = 2'b00;
        cs_begin();
        check("t5_err_cleared", err, 1'b0);
        cs_end();
        wait_idle("t5_idle2");

        // Address wrap, then reset while AW is pending
        clear_logs();
        cs_begin();
        send_byte(8'h02);
        send_word(32'hFFFF_FFFC);
        send_word(32'h0000_0011);
        send_word(32'h0000_0022);
        cs_end();
        wait_idle("t6_idle");
        check("t6_aw_count", aw_log.size(), 2);
        if (aw_log.size() == 2) begin
            check("t6_awaddr0", aw_log[0], 32'hFFFF_FFFC);
            check("t6_awaddr1", aw_log[1], 32'h0000_0000);
        end
        aw_block = 1'b1;
        cs_begin();
        send_byte(8'h02);
        send_word(32'h0000_0010);
        send_word(32'h0000_0033);
        check("t6_awvalid_pre", bus.awvalid, 1'b1);
        check("t6_busy_pre", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_awvalid", bus.awvalid, 1'b0);
        check("t6_rst_wvalid", bus.wvalid, 1'b0);
        check("t6_rst_bready", bus.bready, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_tx_data", tx_data, 8'hFF);
        cs       = 1'b0;
        aw_block = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_post_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
